// File: rtl/stopwatch_dp_if.sv
// Control/display bundle for stopwatch_dp.
// Optional LAP_HOLD_EN adds the i_lap pulse.
interface stopwatch_dp_if;
    logic       i_run_stop;
    logic       i_clear;
`ifdef LAP_HOLD_EN
    logic       i_lap;
`endif
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_running;
    logic       o_tick;

`ifdef LAP_HOLD_EN
    modport master (
        output i_run_stop, i_clear, i_lap,
        input  o_msec, o_sec, o_min, o_hour, o_running, o_tick
    );
    modport slave (
        input  i_run_stop, i_clear, i_lap,
        output o_msec, o_sec, o_min, o_hour, o_running, o_tick
    );
`else
    modport master (
        output i_run_stop, i_clear,
        input  o_msec, o_sec, o_min, o_hour, o_running, o_tick
    );
    modport slave (
        input  i_run_stop, i_clear,
        output o_msec, o_sec, o_min, o_hour, o_running, o_tick
    );
`endif
endinterface

// File: rtl/stopwatch_dp.sv
// Stopwatch datapath: prescaler plus hh:mm:ss.cc counters under a STOP/RUN/CLEAR FSM.
// Define LAP_HOLD_EN to add the i_lap display-freeze feature.
module stopwatch_dp #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic          clk,
    input  logic          reset,
    stopwatch_dp_if.slave bus
);
    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {STOP, RUN, CLEAR} state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   presc_reg, presc_next;
    logic [6:0]      msec_reg,  msec_next;
    logic [5:0]      sec_reg,   sec_next;
    logic [5:0]      min_reg,   min_next;
    logic [4:0]      hour_reg,  hour_next;
    logic            tick_reg;
    logic            wrap;
    logic            msec_carry, sec_carry, min_carry;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= STOP;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            STOP: begin
                if (bus.i_run_stop)   state_next = RUN;
                else if (bus.i_clear) state_next = CLEAR;
            end
            RUN: begin
                if (bus.i_run_stop)   state_next = STOP;
            end
            CLEAR:                    state_next = STOP;
            default:                  state_next = STOP;
        endcase
    end

    // Each field checks its own range first so a corrupted value snaps to 0 on the next tick.
    always_comb begin
        wrap       = (state_reg == RUN) && (presc_reg >= PW'(DIV - 1));
        presc_next = presc_reg;
        msec_next  = msec_reg;
        sec_next   = sec_reg;
        min_next   = min_reg;
        hour_next  = hour_reg;
        msec_carry = 1'b0;
        sec_carry  = 1'b0;
        min_carry  = 1'b0;

        if (state_reg == CLEAR) begin
            presc_next = '0;
            msec_next  = '0;
            sec_next   = '0;
            min_next   = '0;
            hour_next  = '0;
        end else if (state_reg == RUN) begin
            presc_next = wrap ? '0 : presc_reg + 1'b1;
        end

        if (wrap) begin
            msec_carry = (msec_reg == 7'd99);
            msec_next  = (msec_reg >= 7'd99) ? 7'd0 : msec_reg + 7'd1;

            if (sec_reg > 6'd59) begin
                sec_next = '0;
            end else if (msec_carry) begin
                sec_carry = (sec_reg == 6'd59);
                sec_next  = sec_carry ? 6'd0 : sec_reg + 6'd1;
            end

            if (min_reg > 6'd59) begin
                min_next = '0;
            end else if (sec_carry) begin
                min_carry = (min_reg == 6'd59);
                min_next  = min_carry ? 6'd0 : min_reg + 6'd1;
            end

            if (hour_reg > 5'd23) begin
                hour_next = '0;
            end else if (min_carry) begin
                hour_next = (hour_reg == 5'd23) ? 5'd0 : hour_reg + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_reg <= '0;
            msec_reg  <= '0;
            sec_reg   <= '0;
            min_reg   <= '0;
            hour_reg  <= '0;
            tick_reg  <= 1'b0;
        end else begin
            presc_reg <= presc_next;
            msec_reg  <= msec_next;
            sec_reg   <= sec_next;
            min_reg   <= min_next;
            hour_reg  <= hour_next;
            tick_reg  <= wrap;
        end
    end

    assign bus.o_running = (state_reg == RUN);
    assign bus.o_tick    = tick_reg;

`ifdef LAP_HOLD_EN
    logic       hold_reg, hold_next;
    logic [6:0] disp_msec_reg;
    logic [5:0] disp_sec_reg;
    logic [5:0] disp_min_reg;
    logic [4:0] disp_hour_reg;

    always_comb begin
        hold_next = hold_reg;
        if (state_reg == CLEAR)                  hold_next = 1'b0;
        else if (state_reg == RUN && bus.i_lap)  hold_next = ~hold_reg;
    end

    // Display registers keep the pre-edge value when hold is being set, which is the lap snapshot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_reg      <= 1'b0;
            disp_msec_reg <= '0;
            disp_sec_reg  <= '0;
            disp_min_reg  <= '0;
            disp_hour_reg <= '0;
        end else begin
            hold_reg <= hold_next;
            if (!hold_next) begin
                disp_msec_reg <= msec_next;
                disp_sec_reg  <= sec_next;
                disp_min_reg  <= min_next;
                disp_hour_reg <= hour_next;
            end
        end
    end

    assign bus.o_msec = disp_msec_reg;
    assign bus.o_sec  = disp_sec_reg;
    assign bus.o_min  = disp_min_reg;
    assign bus.o_hour = disp_hour_reg;
`else
    assign bus.o_msec = msec_reg;
    assign bus.o_sec  = sec_reg;
    assign bus.o_min  = min_reg;
    assign bus.o_hour = hour_reg;
`endif
endmodule
